ws2812b_rx_decoder: RTL and testbench

//  Receive side of the WS2812B one-wire NRZ link. Decodes a serial stream (as driven by
//  our LED transmitter) back into 24-bit GRB pixel words, counts pixels per frame and

---
 rtl/ws2812b_pkg.sv | 43 ++++
 rtl/ws2812b_sync.sv | 41 ++++
 rtl/ws2812b_rx_decoder.sv | 168 ++++++++++++++++
 tb/tb_ws2812b_rx_decoder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B line timing and framing constants for the transmitter and the
// loopback receiver. All times are in 100 MHz system-clock cycles.
package ws2812b_pkg;

  // Nominal transmit timing
  localparam int WS_T0H        = 40;    // high time of a '0' bit (0.4 us)
  localparam int WS_T1H        = 80;    // high time of a '1' bit (0.8 us)
  localparam int WS_T_BIT      = 125;   // full bit period (1.25 us)
  localparam int WS_T_RESET    = 5000;  // latch / reset low gap (50 us)

  // Receive decision thresholds
  localparam int WS_T_THRESH   = 60;    // high >= this decodes as '1'
  localparam int WS_T_HIGH_MIN = 20;    // shorter high pulses are glitches
  localparam int WS_T_HIGH_MAX = 110;   // a high pulse reaching this is stuck

  // Framing
  localparam int WS_PIX_W      = 24;    // bits per pixel word
  localparam int WS_CNT_W      = 8;     // default pixel counter width

  // GRB word layout: green goes out first, MSB first
  localparam int WS_G_MSB      = 23;
  localparam int WS_G_LSB      = 16;
  localparam int WS_R_MSB      = 15;
  localparam int WS_R_LSB      = 8;
  localparam int WS_B_MSB      = 7;
  localparam int WS_B_LSB      = 0;

  // Receiver state machine
  typedef enum logic [1:0] {
    ST_ARM,   // waiting for a full reset gap before trusting the line
    ST_IDLE,  // between frames, waiting for the first rising edge
    ST_HIGH,  // measuring a high pulse
    ST_LOW    // measuring the low time after a bit
  } rx_state_e;

  // Assemble a pixel word in wire order from its colour components
  function automatic logic [WS_PIX_W-1:0] grb_pack(input logic [7:0] g,
                                                   input logic [7:0] r,
                                                   input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/ws2812b_sync.sv
// Two-flop synchronizer for the asynchronous WS2812B data line, followed by a
// third flop that provides a registered copy of the line together with
// registered rise/fall strobes. The strobes are asserted in the first cycle in
// which o_line shows the new level, so the three outputs stay aligned.
module ws2812b_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_din,
  output logic o_line,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_line;
  logic r_rise;
  logic r_fall;

  // Synchronize din, keep a delayed copy and derive aligned edge strobes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_line <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_line <= r_sync;
      r_rise <= r_sync & ~r_line;
      r_fall <= ~r_sync & r_line;
    end
  end

  assign o_line = r_line;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/ws2812b_rx_decoder.sv
// WS2812B receive decoder: measures synchronized high/low times of the NRZ
// line, turns each high pulse into a bit, assembles 24-bit GRB words, counts
// pixels per frame and reports the latch gap and malformed traffic.
module ws2812b_rx_decoder
  import ws2812b_pkg::*;
#(
  parameter int T_THRESH   = WS_T_THRESH,
  parameter int T_HIGH_MIN = WS_T_HIGH_MIN,
  parameter int T_HIGH_MAX = WS_T_HIGH_MAX,
  parameter int T_RESET    = WS_T_RESET,
  parameter int CNT_W      = WS_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din,
  output logic [WS_PIX_W-1:0] pixel,
  output logic                pixelValid,
  output logic [CNT_W-1:0]    pixelCount,
  output logic                frameDone,
  output logic                bitError
);

  localparam int HC_W = $clog2(T_HIGH_MAX + 1);
  localparam int LC_W = $clog2(T_RESET + 1);

  // Counter increment that holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic w_line;
  logic w_rise;
  logic w_fall;
  logic w_bit;

  rx_state_e           r_state;
  logic [HC_W-1:0]     r_high_cnt;
  logic [LC_W-1:0]     r_low_cnt;
  logic [4:0]          r_bit_cnt;
  logic [WS_PIX_W-2:0] r_shreg;
  logic [WS_PIX_W-1:0] r_pixel;
  logic                r_pix_vld;
  logic [CNT_W-1:0]    r_pix_cnt;
  logic                r_frame_done;
  logic                r_bit_err;
  logic                r_fd_last;

  ws2812b_sync u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_din   (din),
    .o_line  (w_line),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Bit value of the pulse that is ending: long pulses are ones
  assign w_bit = (r_high_cnt >= HC_W'(T_THRESH));

  // Receiver FSM with high/low timers, shift register and pixel/frame strobes.
  // Timers count line cycles including the edge cycle itself, so on a falling
  // edge r_high_cnt equals the number of cycles the line was high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_ARM;
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_pixel      <= '0;
      r_pix_vld    <= 1'b0;
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_bit_err    <= 1'b0;
      r_fd_last    <= 1'b0;
    end else begin
      r_pix_vld    <= 1'b0;
      r_frame_done <= 1'b0;
      r_bit_err    <= 1'b0;

      case (r_state)
        ST_ARM: begin
          // Any high restarts the wait; only a clean reset gap re-arms
          if (w_line) begin
            r_low_cnt <= '0;
          end else if (r_low_cnt == LC_W'(T_RESET - 1)) begin
            r_low_cnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_low_cnt <= r_low_cnt + LC_W'(1);
          end
        end

        ST_IDLE: begin
          if (w_rise) begin
            r_high_cnt <= HC_W'(1);
            r_bit_cnt  <= '0;
            r_state    <= ST_HIGH;
            // First pulse of a new frame restarts the pixel count
            if (r_fd_last) begin
              r_pix_cnt <= '0;
              r_fd_last <= 1'b0;
            end
          end
        end

        ST_HIGH: begin
          if (w_fall) begin
            if (r_high_cnt < HC_W'(T_HIGH_MIN)) begin
              // Too short to be a data bit: treat as a glitch
              r_bit_err <= 1'b1;
              r_bit_cnt <= '0;
              r_low_cnt <= LC_W'(1);
              r_state   <= ST_ARM;
            end else begin
              if (r_bit_cnt == 5'(WS_PIX_W - 1)) begin
                r_pixel   <= {r_shreg, w_bit};
                r_pix_vld <= 1'b1;
                r_bit_cnt <= '0;
                r_pix_cnt <= sat_inc(r_pix_cnt);
              end else begin
                r_shreg   <= {r_shreg[WS_PIX_W-3:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
              r_low_cnt <= LC_W'(1);
              r_state   <= ST_LOW;
            end
          end else if (r_high_cnt == HC_W'(T_HIGH_MAX - 1)) begin
            // Line stuck high: drop the partial word and resynchronize
            r_bit_err <= 1'b1;
            r_bit_cnt <= '0;
            r_low_cnt <= '0;
            r_state   <= ST_ARM;
          end else begin
            r_high_cnt <= r_high_cnt + HC_W'(1);
          end
        end

        ST_LOW: begin
          if (w_rise) begin
            r_high_cnt <= HC_W'(1);
            r_state    <= ST_HIGH;
          end else if (r_low_cnt == LC_W'(T_RESET - 1)) begin
            // Latch gap: frame ends; an unfinished word is reported and dropped
            r_frame_done <= 1'b1;
            r_fd_last    <= 1'b1;
            r_bit_err    <= (r_bit_cnt != 5'd0);
            r_bit_cnt    <= '0;
            r_low_cnt    <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_low_cnt <= r_low_cnt + LC_W'(1);
          end
        end

        default: begin
          r_state <= ST_ARM;
        end
      endcase
    end
  end

  assign pixel      = r_pixel;
  assign pixelValid = r_pix_vld;
  assign pixelCount = r_pix_cnt;
  assign frameDone  = r_frame_done;
  assign bitError   = r_bit_err;

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// Bench for ws2812b_rx_decoder. The line is described as a list of
// (level, length) segments; a segment-level reference model derives the
// expected event stream (pixel words, frame ends, errors and pixel counts)
// directly from the pulse-width and gap rules, and a monitor records the
// strobes the decoder actually produces. Timing is scaled down 5x so that
// whole frames fit in a short run; pixel counter width is reduced so that
// saturation is reached with a handful of pixels.
module tb_ws2812b_rx_decoder;

  localparam int P_THRESH = 12;
  localparam int P_HMIN   = 4;
  localparam int P_HMAX   = 22;
  localparam int P_RESET  = 1000;
  localparam int P_CNT_W  = 3;
  localparam int GAP      = P_RESET + 40;
  localparam int CNT_MAX  = (1 << P_CNT_W) - 1;

  localparam int K_PIX   = 1;
  localparam int K_FD    = 2;
  localparam int K_ERR   = 3;
  localparam int K_FDERR = 4;

  localparam int M_ARM  = 0;
  localparam int M_IDLE = 1;
  localparam int M_LOW  = 2;

  typedef struct {
    int          kind;
    logic [23:0] pix;
    int          cnt;
  } ev_t;

  typedef struct {
    bit lv;
    int len;
  } seg_t;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               din   = 1'b0;
  logic [23:0]        pixel;
  logic               pixelValid;
  logic [P_CNT_W-1:0] pixelCount;
  logic               frameDone;
  logic               bitError;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  seg_t seg_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_st;
  int          m_nbits;
  logic [23:0] m_word;
  logic [23:0] m_pixel;
  int          m_cnt;
  bit          m_fdlast;

  ws2812b_rx_decoder #(
    .T_THRESH   (P_THRESH),
    .T_HIGH_MIN (P_HMIN),
    .T_HIGH_MAX (P_HMAX),
    .T_RESET    (P_RESET),
    .CNT_W      (P_CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .pixel      (pixel),
    .pixelValid (pixelValid),
    .pixelCount (pixelCount),
    .frameDone  (frameDone),
    .bitError   (bitError)
  );

  always #5 clk = ~clk;

  // Record every strobe the decoder emits, with the outputs seen alongside it
  always @(negedge clk) begin
    if (!reset) begin
      ev_t e;
      e.pix = pixel;
      e.cnt = int'(pixelCount);
      e.kind = 0;
      if (pixelValid) begin
        e.kind = K_PIX;
        obs_q.push_back(e);
      end
      if (frameDone && bitError) begin
        e.kind = K_FDERR;
        obs_q.push_back(e);
      end else if (frameDone) begin
        e.kind = K_FD;
        obs_q.push_back(e);
      end else if (bitError) begin
        e.kind = K_ERR;
        obs_q.push_back(e);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_st     = M_ARM;
    m_nbits  = 0;
    m_word   = '0;
    m_pixel  = '0;
    m_cnt    = 0;
    m_fdlast = 1'b0;
  endtask

  task automatic push_exp(input int kind);
    ev_t e;
    e.kind = kind;
    e.pix  = m_pixel;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  // Apply one whole line segment to the model
  task automatic model_seg(input bit lv, input int len);
    if (!lv) begin
      if (m_st == M_ARM) begin
        if (len >= P_RESET) m_st = M_IDLE;
      end else if (m_st == M_LOW && len >= P_RESET) begin
        push_exp((m_nbits != 0) ? K_FDERR : K_FD);
        m_nbits  = 0;
        m_fdlast = 1'b1;
        m_st     = M_IDLE;
      end
    end else if (m_st != M_ARM) begin
      if (m_st == M_IDLE && m_fdlast) begin
        m_cnt    = 0;
        m_fdlast = 1'b0;
      end
      if (len >= P_HMAX || len < P_HMIN) begin
        push_exp(K_ERR);
        m_nbits = 0;
        m_st    = M_ARM;
      end else begin
        m_word = {m_word[22:0], (len >= P_THRESH)};
        m_nbits++;
        if (m_nbits == 24) begin
          m_pixel = m_word;
          m_nbits = 0;
          if (m_cnt < CNT_MAX) m_cnt++;
          push_exp(K_PIX);
        end
        m_st = M_LOW;
      end
    end
  endtask

  task automatic push_seg(input bit lv, input int len);
    if (seg_q.size() > 0 && seg_q[seg_q.size()-1].lv == lv)
      seg_q[seg_q.size()-1].len = seg_q[seg_q.size()-1].len + len;
    else
      seg_q.push_back('{lv, len});
  endtask

  function automatic int hi_len(input bit b);
    return b ? int'($urandom_range(20, 14)) : int'($urandom_range(10, 6));
  endfunction

  // High times sitting exactly on the decision edges
  function automatic int bnd_len(input bit b);
    if (b) return ($urandom_range(1, 0) == 0) ? P_THRESH : P_HMAX - 1;
    return ($urandom_range(1, 0) == 0) ? P_HMIN : P_THRESH - 1;
  endfunction

  task automatic add_bits(input logic [23:0] v, input int nbits, input bit bound);
    for (int i = 23; i > 23 - nbits; i--) begin
      push_seg(1'b1, bound ? bnd_len(v[i]) : hi_len(v[i]));
      push_seg(1'b0, int'($urandom_range(14, 6)));
    end
  endtask

  task automatic add_pixel(input logic [23:0] v, input bit bound);
    add_bits(v, 24, bound);
  endtask

  // Model, drive and compare one batch of segments
  task automatic run_scenario(input string tag);
    exp_q.delete();
    obs_q.delete();
    foreach (seg_q[i]) model_seg(seg_q[i].lv, seg_q[i].len);
    foreach (seg_q[i]) begin
      din = seg_q[i].lv;
      repeat (seg_q[i].len) @(negedge clk);
    end
    din = 1'b0;
    repeat (8) @(negedge clk);
    seg_q.delete();
    check_eq($sformatf("%s.events", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq($sformatf("%s.ev%0d.kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      check_eq($sformatf("%s.ev%0d.pixel", tag, i), obs_q[i].pix, exp_q[i].pix);
      check_eq($sformatf("%s.ev%0d.count", tag, i), obs_q[i].cnt, exp_q[i].cnt);
    end
    check_eq($sformatf("%s.pixel_end", tag), pixel, m_pixel);
    check_eq($sformatf("%s.count_end", tag), pixelCount, m_cnt);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    din   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst.pixel",      pixel,      24'h0);
    check_eq("rst.pixelValid", pixelValid, 1'b0);
    check_eq("rst.pixelCount", pixelCount, 0);
    check_eq("rst.frameDone",  frameDone,  1'b0);
    check_eq("rst.bitError",   bitError,   1'b0);

    // Single pixel frame
    push_seg(1'b0, GAP);
    add_pixel(24'hA53CF0, 1'b0);
    push_seg(1'b0, GAP);
    run_scenario("t1");

    // Three back-to-back pixels, then a one-pixel frame
    add_pixel(24'hFF0000, 1'b0);
    add_pixel(24'h00FF00, 1'b0);
    add_pixel(24'h0000FF, 1'b0);
    push_seg(1'b0, GAP);
    add_pixel(24'($urandom), 1'b0);
    push_seg(1'b0, GAP);
    run_scenario("t2");

    // Short glitch mid-pixel, following pulses ignored until a full gap
    add_bits(24'($urandom), 8, 1'b0);
    push_seg(1'b1, 2);
    push_seg(1'b0, 10);
    push_seg(1'b1, 16);
    push_seg(1'b0, 10);
    push_seg(1'b1, 8);
    push_seg(1'b0, GAP);
    add_pixel(24'($urandom), 1'b0);
    push_seg(1'b0, GAP);
    run_scenario("t3");

    // Partial pixel cut by the latch gap
    add_bits(24'($urandom), 12, 1'b0);
    push_seg(1'b0, GAP);
    run_scenario("t4");

    // Line stuck high, then stray pulses before the re-arm gap
    push_seg(1'b1, 40);
    push_seg(1'b0, 30);
    push_seg(1'b1, 16);
    push_seg(1'b0, 10);
    push_seg(1'b1, 8);
    push_seg(1'b0, GAP);
    add_pixel(24'($urandom), 1'b0);
    push_seg(1'b0, GAP);
    run_scenario("t5");

    // Pulse widths on every decision boundary
    add_pixel(24'($urandom), 1'b1);
    push_seg(1'b0, GAP);
    add_bits(24'($urandom), 5, 1'b0);
    push_seg(1'b1, P_HMIN - 1);
    push_seg(1'b0, GAP);
    add_bits(24'($urandom), 5, 1'b0);
    push_seg(1'b1, P_HMAX);
    push_seg(1'b0, GAP);
    add_pixel(24'($urandom), 1'b1);
    push_seg(1'b0, GAP);
    run_scenario("tb");

    // Reset after 10 bits, then a clean pixel
    add_bits(24'($urandom), 10, 1'b0);
    run_scenario("t6a");
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6.rst_pixel", pixel,      24'h0);
    check_eq("t6.rst_count", pixelCount, 0);
    push_seg(1'b0, GAP);
    add_pixel(24'h123456, 1'b0);
    push_seg(1'b0, GAP);
    run_scenario("t6b");

    // Long frame drives the pixel counter into saturation
    for (int p = 0; p < CNT_MAX + 3; p++) add_pixel(24'($urandom), 1'b0);
    push_seg(1'b0, GAP);
    run_scenario("t6c");

    // Random frames, some ending with a partial word
    for (int f = 0; f < 5; f++) begin
      int npx;
      npx = int'($urandom_range(3, 1));
      for (int p = 0; p < npx; p++) add_pixel(24'($urandom), 1'b0);
      if ($urandom_range(3, 0) == 0) add_bits(24'($urandom), int'($urandom_range(23, 1)), 1'b0);
      push_seg(1'b0, GAP);
      run_scenario($sformatf("rnd%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
